synaptic_current_accumulator: RTL
=================================

# synaptic_current_accumulator

Upstream feeder of the neuron-update stage. Per target neuron it takes a bias current and then a stream of 8-bit sign-magnitude synaptic weights, one per presynaptic neuron, each gated by that neuron's spike bit. It sums the gated weights into a sign-magnitude input current and hands the total to the neuron update over a valid/ready handshake. Addition is sign-magnitude with saturation and a single canonical zero.

## Interface
- NUMWIDTH, 16, magnitude bits of the current; the current word is NUMWIDTH+1 bits, with the MSB as sign (1 = negative).
- CNTW, 8, width of the accepted-spike counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins an accumulation; sampled only in IDLE.
- bias  in  NUMWIDTH+1  sign-magnitude initial current, captured on start.
- w_valid  in  1  weight word valid.
- w_ready  out  1  block can accept a weight.
- w_data  in  8  sign-magnitude weight: bit 7 is sign, bits 6:0 are magnitude.
- w_spike  in  1  presynaptic spike; the weight is summed only when 1.
- w_last  in  1  marks the final word for this neuron.
- i_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- i_data  out  NUMWIDTH+1  accumulated sign-magnitude current.
- i_count  out  CNTW  accepted words with w_spike=1; saturates at 2^CNTW-1.
- i_sat  out  1  magnitude saturated at least once during this accumulation.

## Operation
- States:
  - IDLE: w_ready=0, i_valid=0.
  - ACCUM: w_ready=1.
  - DONE: i_valid=1, w_ready=0.
- Transitions:
  - IDLE→ACCUM on start. On the same edge: acc←bias, with −0 (sign=1, magnitude=0) normalised to +0; count←0; sat←0.
  - ACCUM→DONE on the edge that accepts a word with w_last=1. That word is included in the result.
  - DONE→IDLE on i_valid&&i_ready.
- Acceptance is w_valid&&w_ready. Each accepted word with w_spike=1 updates acc←acc⊕w_data and count←count+1 (saturating). A word with w_spike=0 is consumed without changing acc or count, but its w_last still ends the accumulation.
- start is ignored outside IDLE, including in the DONE cycle in which the handshake completes.
- ⊕ sign-magnitude rules. Let A and W be the magnitudes, with W zero-extended to NUMWIDTH bits.
  - Same sign: magnitude = A+W computed at NUMWIDTH+1 bits. If it exceeds 2^NUMWIDTH−1, clamp it to 2^NUMWIDTH−1, keep the sign, and set sat.
  - Different sign, A>W: sign of acc, magnitude A−W.
  - Different sign, W>A: sign of w_data, magnitude W−A.
  - Different sign, A==W: result is +0 (all zeros). A −0 result is never produced.
  - A weight of −0 (0x80) with w_spike=1 adds nothing but still increments count.
- sat is sticky until the next start.
- i_data, i_count and i_sat are driven directly from registers. They change only on start or on an accepted spiking word, and are stable throughout DONE.

## Timing
- Reset values:
  - state IDLE
  - w_ready=0, i_valid=0
  - i_data=0, i_count=0, i_sat=0
- Reset mid-ACCUM or mid-DONE aborts the operation with no result delivered; the block leaves reset in IDLE.
- start at edge t: w_ready=1 from t+1.
- One word per cycle, with no bubbles while w_valid stays high.
- Last word accepted at edge t: i_valid=1 from t+1 with the final sum.
- Minimum latency is 2 cycles from start to i_valid, for a single-word stream.
- i_valid and i_data hold while i_ready=0.
- After the handshake at edge t: i_valid=0 and state IDLE at t+1. A start at t+1 is accepted.
- Back-to-back throughput is N+2 cycles per neuron for N weights.

## Test plan
- Basic sum: bias=0x00000; spiking weights 0x05, 0x03, 0x82 with last on the third → i_data=0x00006, i_count=3, i_sat=0, i_valid exactly 1 cycle after the last accept.
- Sign crossover: bias=0x00003 (+3); weight 0x8A (−10) with last → i_data=0x10007 (−7). Then bias=0x10004 (−4) with weight 0x04 last → i_data=0x00000, not 0x10000.
- Saturation: bias=0x0FFFA (+65530); weight 0x7F → 0x0FFFF with i_sat=1; then weight 0x81 with last → i_data=0x0FFFE, i_sat still 1.
- Spike gating: bias=0x00010; words (0x7F, spike=0), (0x02, spike=1), (0x7F, spike=0, last) → i_data=0x00012, i_count=1, DONE reached on the non-spiking last word.
- Backpressure and start: hold i_ready=0 for 5 cycles in DONE → i_valid and i_data stable. Pulse start during DONE → ignored. Raise i_ready → IDLE next cycle, and a start then runs a new accumulation.
- Reset mid-operation: drop rst_n asynchronously after 2 of 4 words → all outputs go to 0 immediately with state IDLE. A fresh start with bias 0x10000 (−0) → acc begins at +0, and the sum of weights 0x01, last → 0x00001.

Source files
------------

// File: rtl/synaptic_current_accumulator.sv
// Sums spike-gated sign-magnitude synaptic weights onto a bias current and hands
// the saturated total to the neuron-update stage over a valid/ready handshake.
module synaptic_current_accumulator #(
  parameter int unsigned NUMWIDTH = 16,
  parameter int unsigned CNTW     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUMWIDTH:0]   bias,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [7:0]          w_data,
  input  logic                w_spike,
  input  logic                w_last,
  output logic                i_valid,
  input  logic                i_ready,
  output logic [NUMWIDTH:0]   i_data,
  output logic [CNTW-1:0]     i_count,
  output logic                i_sat
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [NUMWIDTH-1:0] MagMax = '1;

  state_e              state_q;
  logic                w_ready_q;
  logic                i_valid_q;
  logic [NUMWIDTH:0]   acc_q;
  logic [CNTW-1:0]     count_q;
  logic                sat_q;

  logic                accept;
  logic                a_sgn;
  logic                w_sgn;
  logic [NUMWIDTH-1:0] a_mag;
  logic [NUMWIDTH-1:0] w_mag;
  logic [NUMWIDTH:0]   mag_sum;
  logic                sum_sgn;
  logic [NUMWIDTH-1:0] sum_mag;
  logic                sum_ovf;
  logic [NUMWIDTH:0]   bias_norm;
  logic [CNTW-1:0]     count_inc;

  assign accept = w_valid && w_ready_q;

  // Sign-magnitude add of the accumulator and the incoming weight.
  always_comb begin
    a_sgn   = acc_q[NUMWIDTH];
    a_mag   = acc_q[NUMWIDTH-1:0];
    w_sgn   = w_data[7];
    w_mag   = {{(NUMWIDTH - 7){1'b0}}, w_data[6:0]};
    mag_sum = {1'b0, a_mag} + {1'b0, w_mag};
    sum_sgn = a_sgn;
    sum_mag = a_mag;
    sum_ovf = 1'b0;
    if (a_sgn == w_sgn) begin
      if (mag_sum[NUMWIDTH]) begin
        sum_mag = MagMax;
        sum_ovf = 1'b1;
      end else begin
        sum_mag = mag_sum[NUMWIDTH-1:0];
      end
    end else if (a_mag > w_mag) begin
      sum_mag = a_mag - w_mag;
    end else if (w_mag > a_mag) begin
      sum_sgn = w_sgn;
      sum_mag = w_mag - a_mag;
    end else begin
      // Equal magnitudes cancel to the canonical +0.
      sum_sgn = 1'b0;
      sum_mag = '0;
    end
  end

  always_comb begin
    bias_norm = (bias[NUMWIDTH-1:0] == '0) ? '0 : bias;
    count_inc = (count_q == '1) ? count_q : count_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      w_ready_q <= 1'b0;
      i_valid_q <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StAccum;
            w_ready_q <= 1'b1;
            acc_q     <= bias_norm;
            count_q   <= '0;
            sat_q     <= 1'b0;
          end
        end
        StAccum: begin
          if (accept) begin
            if (w_spike) begin
              acc_q   <= {sum_sgn, sum_mag};
              count_q <= count_inc;
              if (sum_ovf) begin
                sat_q <= 1'b1;
              end
            end
            // A non-spiking last word still closes the accumulation.
            if (w_last) begin
              state_q   <= StDone;
              w_ready_q <= 1'b0;
              i_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (i_ready) begin
            state_q   <= StIdle;
            i_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          w_ready_q <= 1'b0;
          i_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign w_ready = w_ready_q;
  assign i_valid = i_valid_q;
  assign i_data  = acc_q;
  assign i_count = count_q;
  assign i_sat   = sat_q;

endmodule
